// File: rtl/decode_stage_p.sv
// Instruction decode stage: 8-entry register file with write-through bypass,
// immediate extension, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_p #(
    parameter int unsigned DATA_W     = 16,
    parameter bit          IMM_SIGNED = 1'b1,
    parameter logic [3:0]  LOAD_OP    = 4'h4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [15:0]       inst_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [2:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hazard,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [2:0]        ex_rd,
    output logic [2:0]        ex_rs1,
    output logic [2:0]        ex_rs2,
    output logic              ex_wr_en,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_imm
);

    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [5:0] imm;

    assign opcode = inst_in[15:12];
    assign rd     = inst_in[11:9];
    assign rs1    = inst_in[8:6];
    assign rs2    = inst_in[5:3];
    assign imm    = inst_in[5:0];

    logic [DATA_W-1:0] rf_q [8];

    // Writeback is independent of flush/stall; only reset blocks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_en) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;

    // Same-cycle writeback bypasses the stored value.
    assign rd_data1 = (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
    assign rd_data2 = (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];

    logic              ext_bit;
    logic [DATA_W-1:0] imm_ext;

    assign ext_bit = IMM_SIGNED ? imm[5] : 1'b0;
    assign imm_ext = {{(DATA_W-6){ext_bit}}, imm};

    logic              ex_valid_q,  ex_valid_d;
    logic [3:0]        ex_opcode_q, ex_opcode_d;
    logic [2:0]        ex_rd_q,     ex_rd_d;
    logic [2:0]        ex_rs1_q,    ex_rs1_d;
    logic [2:0]        ex_rs2_q,    ex_rs2_d;
    logic              ex_wr_en_q,  ex_wr_en_d;
    logic [DATA_W-1:0] ex_data1_q,  ex_data1_d;
    logic [DATA_W-1:0] ex_data2_q,  ex_data2_d;
    logic [DATA_W-1:0] ex_imm_q,    ex_imm_d;

    logic hazard_w;

    assign hazard_w = if_valid && ex_valid_q && (ex_opcode_q == LOAD_OP) &&
                      ((ex_rd_q == rs1) || (ex_rd_q == rs2));

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_opcode_d = ex_opcode_q;
        ex_rd_d     = ex_rd_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        ex_wr_en_d  = ex_wr_en_q;
        ex_data1_d  = ex_data1_q;
        ex_data2_d  = ex_data2_q;
        ex_imm_d    = ex_imm_q;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_wr_en_d = 1'b0;
        end else if (stall) begin
            ex_valid_d = ex_valid_q;
        end else if (hazard_w) begin
            ex_valid_d = 1'b0;
            ex_wr_en_d = 1'b0;
        end else begin
            // Fields are captured even for an invalid slot; only valid/wr_en gate use.
            ex_valid_d  = if_valid;
            ex_wr_en_d  = if_valid && !opcode[3];
            ex_opcode_d = opcode;
            ex_rd_d     = rd;
            ex_rs1_d    = rs1;
            ex_rs2_d    = rs2;
            ex_data1_d  = rd_data1;
            ex_data2_d  = rd_data2;
            ex_imm_d    = imm_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= '0;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_wr_en_q  <= 1'b0;
            ex_data1_q  <= '0;
            ex_data2_q  <= '0;
            ex_imm_q    <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_opcode_q <= ex_opcode_d;
            ex_rd_q     <= ex_rd_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_wr_en_q  <= ex_wr_en_d;
            ex_data1_q  <= ex_data1_d;
            ex_data2_q  <= ex_data2_d;
            ex_imm_q    <= ex_imm_d;
        end
    end

    assign hazard    = hazard_w;
    assign ex_valid  = ex_valid_q;
    assign ex_opcode = ex_opcode_q;
    assign ex_rd     = ex_rd_q;
    assign ex_rs1    = ex_rs1_q;
    assign ex_rs2    = ex_rs2_q;
    assign ex_wr_en  = ex_wr_en_q;
    assign ex_data1  = ex_data1_q;
    assign ex_data2  = ex_data2_q;
    assign ex_imm    = ex_imm_q;

endmodule
